btn_debounce_strobe: RTL and testbench

//   Conditions a raw, asynchronous, bouncing push-button input into a clean

---
 rtl/btn_debounce_strobe.sv | 133 +++++++++++++
 tb/tb_btn_debounce_strobe.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_strobe.sv
// btn_debounce_strobe: synchronizes and debounces a raw push-button.
// Emits one active-low, single-cycle toggle strobe for each accepted press.
// Also exports the debounced level, a qualification-busy flag and a
// wrapping count of accepted presses.
module btn_debounce_strobe #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5,
  parameter int PRESS_CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   btn_raw,
  output logic                   tog_n,
  output logic                   btn_level,
  output logic                   busy,
  output logic [PRESS_CNT_W-1:0] press_count
);

  // The encoding is 3 bits wide, so some values are unreachable.
  // Any unreachable value falls back to RELEASED.
  typedef enum logic [2:0] {
    RELEASED    = 3'd0,
    PRESS_CHK   = 3'd1,
    HELD        = 3'd2,
    RELEASE_CHK = 3'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    btn_s;
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    cnt_done;
  logic                    accept;
  logic                    tog_q, tog_d;
  logic                    level_q, level_d;
  logic                    busy_q, busy_d;
  logic [PRESS_CNT_W-1:0]  press_q, press_d;

  // Metastability synchronizer chain on the asynchronous button input
  always_ff @(posedge clk or posedge areset) begin
    if (areset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  assign btn_s    = sync_q[SYNC_STAGES-1];
  assign cnt_done = (cnt_q == CNT_MAX);

  // State, counter and output registers
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      tog_q   <= 1'b1;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      press_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      level_q <= level_d;
      busy_q  <= busy_d;
      press_q <= press_d;
    end
  end

  // Next-state and counter logic.
  // A CHK state lasts DEBOUNCE_CYCLES cycles when the input is stable.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      RELEASED: begin
        if (btn_s) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_d = RELEASED;         // bounce rejected
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = HELD;
          cnt_d   = '0;
          accept  = 1'b1;             // only path that produces a strobe
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (btn_s) begin
          state_d = HELD;             // bounce rejected, no new strobe
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state.
  // Registering these keeps every output glitch-free.
  always_comb begin
    tog_d   = ~accept;
    press_d = press_q + PRESS_CNT_W'(accept);
    level_d = (state_d == HELD) || (state_d == RELEASE_CHK);
    busy_d  = (state_d == PRESS_CHK) || (state_d == RELEASE_CHK);
  end

  assign tog_n       = tog_q;
  assign btn_level   = level_q;
  assign busy        = busy_q;
  assign press_count = press_q;

endmodule

// File: tb/tb_btn_debounce_strobe.sv
// Directed testbench for btn_debounce_strobe with default parameters.
// The bench also models the downstream 2-state toggle FSM, whose output resets to 1.
module tb_btn_debounce_strobe;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       btn_raw = 1'b0;
  logic       tog_n, btn_level, busy;
  logic [7:0] press_count;
  logic       fsm_q;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  btn_debounce_strobe dut (
    .clk(clk), .areset(areset), .btn_raw(btn_raw), .tog_n(tog_n),
    .btn_level(btn_level), .busy(busy), .press_count(press_count)
  );

  // Downstream toggle FSM model: flips its output on each active-low strobe
  always_ff @(posedge clk or posedge areset) begin
    if (areset)      fsm_q <= 1'b1;
    else if (!tog_n) fsm_q <= ~fsm_q;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset  = 1'b1;
    btn_raw = 1'b0;
    step();
    step();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    btn_raw = 1'b1;
    repeat (25) step();
    n_cmp++; if (press_count !== 8'd1) begin n_err++; $display("FAIL rst_pre_count got=%0d exp=1", press_count); end
    n_cmp++; if (btn_level !== 1'b1) begin n_err++; $display("FAIL rst_pre_level got=%b exp=1", btn_level); end
    #3 areset = 1'b1;
    #1;
    n_cmp++; if (tog_n !== 1'b1) begin n_err++; $display("FAIL rst_tog_n got=%b exp=1", tog_n); end
    n_cmp++; if (btn_level !== 1'b0) begin n_err++; $display("FAIL rst_level got=%b exp=0", btn_level); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_cmp++; if (press_count !== 8'd0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", press_count); end
    btn_raw = 1'b0;
    step();
    areset = 1'b0;
  endtask

  task automatic test_clean_press();
    int first, lows;
    first = -1; lows = 0;
    do_reset();
    btn_raw = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (!tog_n) begin lows++; if (first < 0) first = k; end
      if (k == 3) begin
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL clean_busy got=%b exp=1", busy); end
      end
      if (k == 18) begin
        n_cmp++; if (btn_level !== 1'b0) begin n_err++; $display("FAIL clean_level_early got=%b exp=0", btn_level); end
      end
    end
    n_cmp++; if (first !== 19) begin n_err++; $display("FAIL clean_latency got=%0d exp=19", first); end
    n_cmp++; if (lows !== 1) begin n_err++; $display("FAIL clean_strobe_len got=%0d exp=1", lows); end
    n_cmp++; if (btn_level !== 1'b1) begin n_err++; $display("FAIL clean_level got=%b exp=1", btn_level); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL clean_busy_end got=%b exp=0", busy); end
    n_cmp++; if (press_count !== 8'd1) begin n_err++; $display("FAIL clean_count got=%0d exp=1", press_count); end
  endtask

  // The button is high for edges 1-10, low for 11-13 and high from edge 14
  task automatic test_press_bounce();
    int first, lows;
    first = -1; lows = 0;
    do_reset();
    for (int k = 1; k <= 43; k++) begin
      btn_raw = (k <= 10 || k >= 14);
      step();
      if (!tog_n) begin lows++; if (first < 0) first = k; end
    end
    n_cmp++; if (first !== 32) begin n_err++; $display("FAIL pbounce_latency got=%0d exp=32", first); end
    n_cmp++; if (lows !== 1) begin n_err++; $display("FAIL pbounce_strobes got=%0d exp=1", lows); end
    n_cmp++; if (press_count !== 8'd1) begin n_err++; $display("FAIL pbounce_count got=%0d exp=1", press_count); end
  endtask

  // Starts in HELD: low 5, high 20, then low from edge 26 (release at 26+18)
  task automatic test_release_bounce();
    int first_rel, lows, level_bad;
    first_rel = -1; lows = 0; level_bad = 0;
    for (int k = 1; k <= 55; k++) begin
      btn_raw = (k > 5 && k <= 25);
      step();
      if (!tog_n) lows++;
      if (k <= 43 && btn_level !== 1'b1) level_bad++;
      if (btn_level === 1'b0 && first_rel < 0) first_rel = k;
      if (k == 3) begin
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rbounce_busy got=%b exp=1", busy); end
      end
    end
    n_cmp++; if (lows !== 0) begin n_err++; $display("FAIL rbounce_strobes got=%0d exp=0", lows); end
    n_cmp++; if (level_bad !== 0) begin n_err++; $display("FAIL rbounce_level_drop got=%0d exp=0", level_bad); end
    n_cmp++; if (first_rel !== 44) begin n_err++; $display("FAIL rbounce_release_edge got=%0d exp=44", first_rel); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rbounce_busy_end got=%b exp=0", busy); end
    n_cmp++; if (press_count !== 8'd1) begin n_err++; $display("FAIL rbounce_count got=%0d exp=1", press_count); end
  endtask

  // Reset arrives after edge 11 (cnt=8) while the button stays held
  task automatic test_reset_mid_chk();
    int first, lows;
    first = -1; lows = 0;
    do_reset();
    btn_raw = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (!tog_n) lows++;
    end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_pre_busy got=%b exp=1", busy); end
    areset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    n_cmp++; if (tog_n !== 1'b1) begin n_err++; $display("FAIL midrst_tog_n got=%b exp=1", tog_n); end
    step();
    step();
    areset = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (!tog_n) begin lows++; if (first < 0) first = k; end
    end
    n_cmp++; if (first !== 19) begin n_err++; $display("FAIL midrst_latency got=%0d exp=19", first); end
    n_cmp++; if (lows !== 1) begin n_err++; $display("FAIL midrst_strobes got=%0d exp=1", lows); end
    n_cmp++; if (press_count !== 8'd1) begin n_err++; $display("FAIL midrst_count got=%0d exp=1", press_count); end
  endtask

  task automatic test_wrap();
    int lows;
    lows = 0;
    do_reset();
    for (int p = 0; p < 256; p++) begin
      btn_raw = 1'b1;
      repeat (20) begin step(); if (!tog_n) lows++; end
      btn_raw = 1'b0;
      repeat (20) begin step(); if (!tog_n) lows++; end
      if (p == 254) begin
        n_cmp++; if (press_count !== 8'd255) begin n_err++; $display("FAIL wrap_max got=%0d exp=255", press_count); end
        n_cmp++; if (fsm_q !== 1'b0) begin n_err++; $display("FAIL wrap_fsm_255 got=%b exp=0", fsm_q); end
      end
    end
    n_cmp++; if (press_count !== 8'd0) begin n_err++; $display("FAIL wrap_count got=%0d exp=0", press_count); end
    n_cmp++; if (lows !== 256) begin n_err++; $display("FAIL wrap_strobes got=%0d exp=256", lows); end
    n_cmp++; if (fsm_q !== 1'b1) begin n_err++; $display("FAIL wrap_fsm_out got=%b exp=1", fsm_q); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_reset_mid_chk();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
